// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage. Owns the PC, drives a combinational IM read port and
// buffers fetched words (with their PC and an address-error flag) in a DEPTH-entry FIFO that
// decode drains over a valid/ready handshake. Redirects and exception entry flush the FIFO.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   im_addr_o/im_enable_o IM fetch address (= pc) and read strobe
//   im_data_i             IM read data, combinational from im_addr_o
//   redirect_valid_i/_pc  branch/jump/eret redirect request and target
//   exc_req_i             exception entry, target ISR_ADDR
//   out_valid_o/_ready_i  FIFO head handshake
//   out_instr_o/_pc_o     head instruction word and its address
//   out_adel_o            head fetch address error (misaligned or out of range)
module if_fetch_queue #(
  parameter logic [31:0] START_ADDR = 32'h0000_3000,
  parameter logic [31:0] ISR_ADDR   = 32'h0000_4180,
  parameter logic [31:0] ADDR_LB    = 32'h0000_3000,
  parameter logic [31:0] ADDR_UB    = 32'h0000_6FFC,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr_o,
  output logic        im_enable_o,
  input  logic [31:0] im_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        exc_req_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_adel_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW:0]   count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_pc_q    [DEPTH];
  logic        mem_adel_q  [DEPTH];

  logic pop, space, flush, fetch, adel;
  logic [31:0] word;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign space       = (count_q < FullCnt) | ((count_q == FullCnt) & pop);
  assign flush       = exc_req_i | redirect_valid_i;
  assign fetch       = rst_n & ~flush & space;

  assign im_addr_o   = pc_q;
  assign im_enable_o = fetch;

  assign adel = (pc_q[1:0] != 2'b00) | (pc_q < ADDR_LB) | (pc_q > ADDR_UB);
  // Never forward data read from an illegal address.
  assign word = adel ? 32'h0 : im_data_i;

  assign out_instr_o = mem_instr_q[rd_ptr_q];
  assign out_pc_o    = mem_pc_q[rd_ptr_q];
  assign out_adel_o  = mem_adel_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // Exception entry outranks a redirect; any pop this cycle is discarded.
      pc_d     = exc_req_i ? ISR_ADDR : redirect_pc_i;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (fetch) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (fetch && !pop) begin
        count_d = count_q + (PtrW + 1)'(1);
      end else if (!fetch && pop) begin
        count_d = count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= START_ADDR;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is reset so the head fields read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr_q[i] <= 32'h0;
        mem_pc_q[i]    <= 32'h0;
        mem_adel_q[i]  <= 1'b0;
      end
    end else if (fetch) begin
      mem_instr_q[wr_ptr_q] <= word;
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_adel_q[wr_ptr_q]  <= adel;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic        im_enable;
  logic [31:0] im_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_adel;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory model: an address-dependent pattern.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign im_data = im_word(im_addr);

  if_fetch_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .im_addr_o        (im_addr),
    .im_enable_o      (im_enable),
    .im_data_i        (im_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .exc_req_i        (exc_req),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .out_adel_o       (out_adel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic        exc;
    logic [31:0] rpc;
    logic        ov;
    logic [31:0] opc;
    logic        adel;
    logic [31:0] ia;
    logic        ie;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic redir, input logic exc,
                              input logic [31:0] rpc, input logic ov, input logic [31:0] opc,
                              input logic adel, input logic [31:0] ia, input logic ie);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.exc = exc; v.rpc = rpc;
    v.ov = ov; v.opc = opc; v.adel = adel; v.ia = ia; v.ie = ie;
    return v;
  endfunction

  localparam int NV = 23;
  vec_t vecs [NV];

  initial begin
    // Each row: inputs held during the cycle, and outputs expected in that cycle before the edge.
    //            rdy   rd    exc   rpc            ov    out_pc         adel  im_addr        im_en
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_3000, 1'b1);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 32'h0000_3004, 1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_3004, 1'b0, 32'h0000_3008, 1'b1);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_3004, 1'b0, 32'h0000_300C, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_3004, 1'b0, 32'h0000_300C, 1'b1);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_3008, 1'b0, 32'h0000_3010, 1'b1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_300C, 1'b0, 32'h0000_3014, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b0, 32'h0000_3100, 1'b1, 32'h0000_300C, 1'b0, 32'h0000_3014, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_3100, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 1'b1, 32'h0000_3200, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_3104, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_4180, 1'b1);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 32'h0000_3002, 1'b1, 32'h0000_4180, 1'b0, 32'h0000_4184, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_3002, 1'b1);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0000_2FFC, 1'b1, 32'h0000_3002, 1'b1, 32'h0000_3006, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_2FFC, 1'b1);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_2FFC, 1'b1, 32'h0000_3000, 1'b1);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 32'h0000_6FFC, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3004, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_6FFC, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_6FFC, 1'b0, 32'h0000_7000, 1'b1);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_7000, 1'b1, 32'h0000_7004, 1'b0);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b1);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b1);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004, 1'b1);

    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exc_req        = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst out_instr", out_instr, 32'h0);
    chk("rst out_pc", out_pc, 32'h0);
    chk("rst out_adel", {31'h0, out_adel}, 32'h0);
    chk("rst im_enable", {31'h0, im_enable}, 32'h0);
    chk("rst im_addr", im_addr, 32'h0000_3000);
    @(posedge clk);

    // Table-driven run from reset release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge clk);
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].redir;
      exc_req        = vecs[i].exc;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ov});
      chk($sformatf("v%0d im_addr", i), im_addr, vecs[i].ia);
      chk($sformatf("v%0d im_enable", i), {31'h0, im_enable}, {31'h0, vecs[i].ie});
      if (vecs[i].ov) begin
        chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].opc);
        chk($sformatf("v%0d out_adel", i), {31'h0, out_adel}, {31'h0, vecs[i].adel});
        chk($sformatf("v%0d out_instr", i), out_instr,
            vecs[i].adel ? 32'h0 : im_word(vecs[i].opc));
      end
    end

    // Mid-cycle asynchronous reset with two entries queued.
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3400;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-rst out_pc", out_pc, 32'h0000_3400);
    chk("pre-rst im_addr", im_addr, 32'h0000_3408);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("async rst im_enable", {31'h0, im_enable}, 32'h0);
    chk("async rst im_addr", im_addr, 32'h0000_3000);
    chk("async rst out_pc", out_pc, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("restart im_addr", im_addr, 32'h0000_3000);
    chk("restart im_enable", {31'h0, im_enable}, 32'h1);
    chk("restart out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("restart head valid", {31'h0, out_valid}, 32'h1);
    chk("restart head pc", out_pc, 32'h0000_3000);
    chk("restart head instr", out_instr, im_word(32'h0000_3000));
    chk("restart im_addr next", im_addr, 32'h0000_3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
